// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU datapath blocks (adder, divider).
//   state_t   - divider FSM states
//   ALU_WIDTH - default operand width used across the ALU
//   clog2     - ceiling log2, usable in constant expressions for sizing
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   p     [WIDTH:0]   partial remainder in
//   q     [WIDTH-1:0] dividend/quotient shift register in
//   d     [WIDTH-1:0] divisor
//   p_nxt [WIDTH:0]   partial remainder out
//   q_nxt [WIDTH-1:0] shift register out, new quotient bit in the LSB
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] trial;
    logic           borrow;
    // P stays below D between iterations, so its top bit is always zero and
    // only the low WIDTH bits take part in the shift.
    logic           p_msb_unused;

    assign p_msb_unused = p[WIDTH];
    assign p_shift      = {p[WIDTH-1:0], q[WIDTH-1]};
    assign trial        = p_shift - {1'b0, d};
    assign borrow       = trial[WIDTH];

    // On borrow the subtraction is discarded (restored) and the quotient bit is 0.
    assign p_nxt = borrow ? p_shift : trial;
    assign q_nxt = {q[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned divider, one quotient bit per clock.
//   clk, rst          clock; asynchronous active-high reset
//   start             request, sampled only while idle
//   A, B              dividend, divisor (latched on accepted start)
//   quotient          result of last completed operation
//   remainder         remainder of last completed operation
//   dbz               last completed operation had B == 0
//   busy              iteration in progress
//   done              one-cycle pulse when the result registers update
// A zero divisor completes straight from IDLE with quotient all-ones and
// remainder = A; otherwise the result arrives WIDTH clocks after the start.
module restoring_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = clog2(WIDTH + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAST_ITER = cnt_t'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    cnt_t             cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] q_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p     (p_q),
        .q     (q_q),
        .d     (d_q),
        .p_nxt (p_nxt),
        .q_nxt (q_nxt)
    );

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        q_d     = A;
                        d_d     = B;
                        p_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        // Zero divisor never enters RUN; result is immediate.
                        quotient_d  = '1;
                        remainder_d = A;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            RUN: begin
                p_d   = p_nxt;
                q_d   = q_nxt;
                cnt_d = cnt_q + cnt_t'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    quotient_d  = q_nxt;
                    remainder_d = p_nxt[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors for the 8-bit restoring divider.
module tb_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;
    logic       busy;
    logic       done;

    int n_vec;
    int n_miss;

    restoring_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns edges after the start sample until done is seen; 0 if never.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic edz);
        int lat;
        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        if (b == 8'd0) begin
            chk({tag, "_done_now"}, done, 1);
            chk({tag, "_busy_low"}, busy, 0);
        end else begin
            chk({tag, "_busy"}, busy, 1);
            wait_done(lat);
            chk({tag, "_lat"}, lat, 8);
        end
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, dbz, edz);
        tick();
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        n_vec = 0; n_miss = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #2;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();

        run_div("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
        run_div("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
        run_div("d5_9",     8'd5,   8'd9,   8'd0,   8'd5,   1'b0);
        run_div("d200_200", 8'd200, 8'd200, 8'd1,   8'd0,   1'b0);
        run_div("d0_5",     8'd0,   8'd5,   8'd0,   8'd0,   1'b0);
        run_div("d255_2",   8'd255, 8'd2,   8'd127, 8'd1,   1'b0);
        run_div("d254_255", 8'd254, 8'd255, 8'd0,   8'd254, 1'b0);
        run_div("dbz200",   8'd200, 8'd0,   8'hFF,  8'd200, 1'b1);
        run_div("d9_3",     8'd9,   8'd3,   8'd3,   8'd0,   1'b0);

        // Start while busy must be ignored.
        A = 8'd100; B = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        A = 8'd50; B = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", busy, 1);
        lat = 0;
        for (int i = 4; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("ign_lat", lat, 8);
        chk("ign_q", quotient, 14);
        chk("ign_r", remainder, 2);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("ign_pulses", pulses, 0);

        // Asynchronous reset mid-operation.
        run_div("pre_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        A = 8'd100; B = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        tick(); tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        chk("arst_quiet", pulses, 0);
        run_div("d63_8", 8'd63, 8'd8, 8'd7, 8'd7, 1'b0);

        // Back-to-back: new start issued in the done cycle.
        A = 8'd100; B = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("b2b_lat1", lat, 8);
        chk("b2b_q1", quotient, 14);
        A = 8'd77; B = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_done_clr", done, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_q", quotient, 14);
        chk("b2b_hold_r", remainder, 2);
        wait_done(lat);
        chk("b2b_lat2", lat, 8);
        chk("b2b_q2", quotient, 7);
        chk("b2b_r2", remainder, 7);
        chk("b2b_dbz2", dbz, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Multi-cycle unsigned integer divider for the ALU. It is the inverse-direction companion of the registered adder: it divides by repeated shift-and-subtract with borrow detection, where the adder combines by addition with carry.
- Accepts a dividend/divisor pair on a start pulse.
- Iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Sits beside the adder in the ALU datapath; the ALU controller owns start/done sequencing.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only while idle
A  input  WIDTH  dividend (unsigned)
B  input  WIDTH  divisor (unsigned)
quotient  output  WIDTH  registered quotient of last completed operation
remainder  output  WIDTH  registered remainder of last completed operation
dbz  output  1  divide-by-zero flag of last completed operation
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when quotient/remainder/dbz update

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - While rst is high: quotient=0, remainder=0, dbz=0, busy=0, done=0, state=IDLE, internal registers=0.
  - Reset mid-operation aborts the operation with no result and no done pulse.
- States: IDLE, RUN.
- IDLE:
  - On edge E0 with start=1 and B!=0: latch A into the Q shift register and B into the D register; clear the partial remainder P (WIDTH+1 bits); set iteration count=0; busy=1; go to RUN.
  - On edge E0 with start=1 and B==0: stay in IDLE, busy stays 0. At E0 register quotient={WIDTH{1}}, remainder=A, dbz=1, done=1. The result is therefore visible one cycle after the start sample.
  - start=0: no change.
- RUN, one iteration per edge E1..E_WIDTH:
  - Pshift = {P[WIDTH-1:0], Q[WIDTH-1]}.
  - trial = Pshift - {1'b0, D}, computed at WIDTH+1 bits.
  - If trial MSB=0 (no borrow): P=trial, Q={Q[WIDTH-2:0],1}.
  - If trial MSB=1 (borrow): P=Pshift, Q={Q[WIDTH-2:0],0}.
  - Increment the count.
- Completion at edge E_WIDTH (the WIDTH-th iteration):
  - Register quotient=new Q, remainder=new P[WIDTH-1:0], dbz=0, done=1, busy=0.
  - Return to IDLE.
  - Latency: done is high in the cycle after E_WIDTH, i.e. 8 clocks after the start sample for WIDTH=8.
- done is high for exactly one cycle and is cleared on the next edge unless a new zero-divisor start completes on that same edge.
- Result registers hold their value between operations. They change only at completion or on reset.
- start while busy=1 is ignored and is not queued. A and B are don't-care during RUN because the operands were latched at E0.
- Back-to-back: start may be asserted in the cycle where done=1. The state is IDLE then, so it is accepted.
- Width rules: all arithmetic is unsigned. P never exceeds D-1 after any iteration, so the remainder fits in WIDTH bits. There is no overflow case other than B==0.

Decomposition:
- Shared package alu_pkg:
  - state enum (IDLE, RUN);
  - default data width constant ALU_WIDTH=8, shared with the adder;
  - function clog2 for sizing the counter at $clog2(WIDTH+1) bits.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: P, Q, D.
  - Outputs: next P, next Q.
  - Parameterised by WIDTH; instantiated once inside restoring_divider.
- The top level holds the FSM, counter, operand registers and result registers.

Test Plan:
- WIDTH=8, A=100, B=7, start pulse at E0 -> busy=1 from E0; done=1 exactly after E8; quotient=14, remainder=2, dbz=0.
- A=255, B=1 -> quotient=255, remainder=0. Then A=5, B=9 -> quotient=0, remainder=5. Then A=200, B=200 -> quotient=1, remainder=0.
- A=200, B=0, start -> done after E0 (no RUN); quotient=8'hFF, remainder=200, dbz=1, busy never high. A following 9/3 -> dbz returns to 0, quotient=3, remainder=0.
- Start 100/7; at E3 drive start=1 with A=50, B=5 -> ignored; result still 14 r 2 at E8, then only one done pulse.
- Start 100/7; assert rst asynchronously between E4 and E5 -> all outputs 0 immediately, no done pulse. After release, start 63/8 -> quotient=7, remainder=7.
- Start 100/7; re-assert start with 77/10 in the done cycle -> second done exactly 8 cycles later with quotient=7, remainder=7; first result held until then.
